// File: rtl/tour_cmd_seq.sv
// Command sequencer: passes UART commands through to cmd_proc, or replays a 24-move knight's tour
// as vertical-then-horizontal leg commands. Define TOUR_FANFARE_EN to use opcode 4'h5 on the final leg.
module tour_cmd_seq (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start_tour,
   output logic [4:0]  mv_addr,
   input  logic [7:0]  mv_data,
   input  logic [15:0] uart_cmd,
   input  logic        uart_cmd_rdy,
   output logic        uart_clr_cmd_rdy,
   output logic [15:0] cmd,
   output logic        cmd_rdy,
   input  logic        clr_cmd_rdy,
   input  logic        send_resp,
   output logic        resp_snd,
   output logic [7:0]  resp,
   output logic        tour_active,
   output logic        tour_err
);

   typedef enum logic [2:0] {IDLE, PASS, LOAD, VLEG, VWAIT, HLEG, HWAIT, DONE} state_t;

   localparam logic [4:0] LAST_MOVE = 5'd23;
   localparam logic [3:0] OP_MOVE   = 4'h4;
`ifdef TOUR_FANFARE_EN
   localparam logic [3:0] OP_LAST   = 4'h5;
`else
   localparam logic [3:0] OP_LAST   = 4'h4;
`endif

   state_t      r_state;
   logic [15:0] r_cmd;
   logic        r_cmd_rdy;
   logic        r_uclr;
   logic        r_resp_snd;
   logic [7:0]  r_resp;
   logic [4:0]  r_mv_addr;
   logic        r_active;
   logic        r_err;
   logic [7:0]  r_move;
   logic        r_ld_wait;
   logic [3:0]  w_hop;

   function automatic logic is_onehot(input logic [7:0] m);
      is_onehot = (m != 8'h00) && ((m & (m - 8'h01)) == 8'h00);
   endfunction

   // Only called with a one-hot move, so the defaults cover the remaining bits.
   function automatic logic signed [2:0] move_dx(input logic [7:0] m);
      case (m)
         8'h01, 8'h20: move_dx = 3'sd1;
         8'h02, 8'h10: move_dx = -3'sd1;
         8'h04, 8'h08: move_dx = -3'sd2;
         default:      move_dx = 3'sd2;
      endcase
   endfunction

   function automatic logic signed [2:0] move_dy(input logic [7:0] m);
      case (m)
         8'h01, 8'h02: move_dy = 3'sd2;
         8'h04, 8'h80: move_dy = 3'sd1;
         8'h08, 8'h40: move_dy = -3'sd1;
         default:      move_dy = -3'sd2;
      endcase
   endfunction

   function automatic logic [15:0] leg_cmd(input logic [3:0] op, input logic signed [2:0] d,
                                           input logic vert);
      logic [7:0] hdg;
      logic [2:0] mag;
      if (vert) hdg = d[2] ? 8'h7F : 8'h00;
      else      hdg = d[2] ? 8'h3F : 8'hBF;
      mag = d[2] ? (3'd0 - d) : d;
      leg_cmd = {op, hdg, 1'b0, mag};
   endfunction

   assign w_hop = (r_mv_addr == LAST_MOVE) ? OP_LAST : OP_MOVE;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_cmd      <= 16'h0000;
         r_cmd_rdy  <= 1'b0;
         r_uclr     <= 1'b0;
         r_resp_snd <= 1'b0;
         r_resp     <= 8'h00;
         r_mv_addr  <= 5'd0;
         r_active   <= 1'b0;
         r_err      <= 1'b0;
         r_move     <= 8'h00;
         r_ld_wait  <= 1'b0;
      end else begin
         r_uclr     <= 1'b0;
         r_resp_snd <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start_tour) begin
                  r_mv_addr <= 5'd0;
                  r_active  <= 1'b1;
                  r_err     <= 1'b0;
                  r_ld_wait <= 1'b1;
                  r_state   <= LOAD;
               end else if (uart_cmd_rdy) begin
                  r_cmd     <= uart_cmd;
                  r_cmd_rdy <= 1'b1;
                  r_uclr    <= 1'b1;
                  r_state   <= PASS;
               end
            end
            PASS: begin
               if (r_cmd_rdy) begin
                  if (clr_cmd_rdy) r_cmd_rdy <= 1'b0;
               end else if (send_resp) begin
                  r_resp_snd <= 1'b1;
                  r_resp     <= 8'hA5;
                  r_state    <= IDLE;
               end
            end
            LOAD: begin
               // First cycle covers the move memory's read latency.
               if (r_ld_wait) begin
                  r_ld_wait <= 1'b0;
               end else if (is_onehot(mv_data)) begin
                  r_move    <= mv_data;
                  r_cmd     <= leg_cmd(OP_MOVE, move_dy(mv_data), 1'b1);
                  r_cmd_rdy <= 1'b1;
                  r_state   <= VLEG;
               end else begin
                  r_err      <= 1'b1;
                  r_active   <= 1'b0;
                  r_resp     <= 8'h45;
                  r_resp_snd <= 1'b1;
                  r_state    <= IDLE;
               end
            end
            VLEG: begin
               if (clr_cmd_rdy) begin
                  r_cmd_rdy <= 1'b0;
                  r_state   <= VWAIT;
               end
            end
            VWAIT: begin
               if (send_resp) begin
                  r_cmd     <= leg_cmd(w_hop, move_dx(r_move), 1'b0);
                  r_cmd_rdy <= 1'b1;
                  r_state   <= HLEG;
               end
            end
            HLEG: begin
               if (clr_cmd_rdy) begin
                  r_cmd_rdy <= 1'b0;
                  r_state   <= HWAIT;
               end
            end
            HWAIT: begin
               if (send_resp) begin
                  if (r_mv_addr < LAST_MOVE) begin
                     r_mv_addr <= r_mv_addr + 5'd1;
                     r_ld_wait <= 1'b1;
                     r_state   <= LOAD;
                  end else begin
                     r_state <= DONE;
                  end
               end
            end
            DONE: begin
               r_resp_snd <= 1'b1;
               r_resp     <= 8'hA5;
               r_active   <= 1'b0;
               r_state    <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign mv_addr          = r_mv_addr;
   assign cmd              = r_cmd;
   assign cmd_rdy          = r_cmd_rdy;
   assign uart_clr_cmd_rdy = r_uclr;
   assign resp_snd         = r_resp_snd;
   assign resp             = r_resp;
   assign tour_active      = r_active;
   assign tour_err         = r_err;

endmodule
